hilo_multdiv: RTL and testbench

Execute-stage multi-cycle multiply/divide unit for the 5-stage MIPS core. It consumes the operation code and operands latched in the ID/EX pipeline register and produces the HI/LO results. While it works, it drives the stall request that freezes that same register. It holds the finished result until the pipeline advances, then issues a one-cycle HI/LO write.

---
 rtl/hilo_multdiv_pkg.sv | 19 +
 rtl/hilo_multdiv_div_iter.sv | 74 +++++++
 rtl/hilo_multdiv.sv | 128 ++++++++++++
 tb/tb_hilo_multdiv.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hilo_multdiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes, word type
// and the operand magnitude helper used by the divider.
package hilo_multdiv_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      CLR   = 3'd0,
      MULT  = 3'd1,
      MULTU = 3'd2,
      DIV   = 3'd3,
      DIVU  = 3'd4
   } mult_t;

   function automatic word_t magnitude(input word_t w, input logic sgn);
      return (sgn && w[31]) ? -w : w;
   endfunction

endpackage

// File: rtl/hilo_multdiv_div_iter.sv
// Restoring divider on operand magnitudes, one quotient bit per cycle, with the
// sign fixup applied to the final-step values so they can be captured on done.
module hilo_multdiv_div_iter
   import hilo_multdiv_pkg::*;
#(
   parameter int ITERS = 32
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  start,
   input  logic  abort,
   input  word_t dividend,
   input  word_t divisor,
   input  logic  is_signed,
   output logic  done,
   output word_t quotient,
   output word_t remainder
);

   localparam int CW = $clog2(ITERS);

   logic          active;
   logic [CW-1:0] cnt;
   word_t         rem_q, quo_q, dvs_q;
   logic          q_neg, r_neg;
   logic [32:0]   shifted;
   logic          fits;
   word_t         rem_n, quo_n;

   // A zero divisor always "fits", which yields an all-ones quotient and the
   // dividend magnitude as remainder without any special casing.
   always_comb begin
      shifted   = {rem_q, quo_q[31]};
      fits      = (shifted >= {1'b0, dvs_q});
      rem_n     = fits ? 32'(shifted - {1'b0, dvs_q}) : shifted[31:0];
      quo_n     = {quo_q[30:0], fits};
      done      = active && (cnt == CW'(ITERS - 1));
      quotient  = q_neg ? -quo_n : quo_n;
      remainder = r_neg ? -rem_n : rem_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active <= 1'b0;
         cnt    <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
      end else if (abort) begin
         active <= 1'b0;
         cnt    <= '0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= '0;
         rem_q  <= '0;
         quo_q  <= magnitude(dividend, is_signed);
         dvs_q  <= magnitude(divisor, is_signed);
         q_neg  <= is_signed && (dividend[31] ^ divisor[31]);
         r_neg  <= is_signed && dividend[31];
      end else if (active) begin
         rem_q <= rem_n;
         quo_q <= quo_n;
         if (done) begin
            active <= 1'b0;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/hilo_multdiv.sv
// Execute-stage multiply/divide unit: stalls ID/EX while working, holds the
// result in DONE until the pipeline advances, then writes HI/LO for one cycle.
//
// state  | meaning
// S_IDLE | waiting for a mult/div op in ID/EX
// S_MUL  | product pipeline running
// S_DIV  | restoring divide iterating
// S_DONE | result held, waiting for ex_advance to write HI/LO
module hilo_multdiv
   import hilo_multdiv_pkg::*;
#(
   parameter int DIV_ITERS  = 32,
   parameter int MUL_CYCLES = 1
) (
   input  logic  clk,
   input  logic  reset,
   input  mult_t op,
   input  word_t src_a,
   input  word_t src_b,
   input  logic  flush,
   input  logic  ex_advance,
   output logic  busy,
   output word_t hi_out,
   output word_t lo_out,
   output logic  hilo_we
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   state_t         state, state_n;
   logic [MCW-1:0] mul_cnt;
   logic [63:0]    prod_q;
   logic [63:0]    ext_a, ext_b;
   logic           is_mul_op, is_div_op, op_signed, accept;
   logic           load_mul, load_div, div_done;
   word_t          div_quo, div_rem;

   always_comb begin
      is_mul_op = (op == MULT) || (op == MULTU);
      is_div_op = (op == DIV) || (op == DIVU);
      op_signed = (op == MULT) || (op == DIV);
      accept    = (state == S_IDLE) && (is_mul_op || is_div_op) && !flush;
      ext_a     = {{32{op_signed & src_a[31]}}, src_a};
      ext_b     = {{32{op_signed & src_b[31]}}, src_b};
   end

   // flush outranks completion and ex_advance in every state.
   always_comb begin
      state_n  = state;
      busy     = 1'b0;
      hilo_we  = 1'b0;
      load_mul = 1'b0;
      load_div = 1'b0;
      case (state)
         S_IDLE: begin
            busy = accept;
            if (accept) state_n = is_div_op ? S_DIV : S_MUL;
         end
         S_MUL: begin
            busy = 1'b1;
            if (flush) state_n = S_IDLE;
            else if (mul_cnt == '0) begin
               load_mul = 1'b1;
               state_n  = S_DONE;
            end
         end
         S_DIV: begin
            busy = 1'b1;
            if (flush) state_n = S_IDLE;
            else if (div_done) begin
               load_div = 1'b1;
               state_n  = S_DONE;
            end
         end
         S_DONE: begin
            if (flush) state_n = S_IDLE;
            else if (ex_advance) begin
               hilo_we = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         mul_cnt <= '0;
         prod_q  <= '0;
         hi_out  <= '0;
         lo_out  <= '0;
      end else begin
         state <= state_n;
         if (accept && is_mul_op) begin
            prod_q  <= ext_a * ext_b;
            mul_cnt <= MCW'(MUL_CYCLES - 1);
         end else if (state == S_MUL && mul_cnt != '0) begin
            mul_cnt <= mul_cnt - MCW'(1);
         end
         if (load_mul) begin
            hi_out <= prod_q[63:32];
            lo_out <= prod_q[31:0];
         end else if (load_div) begin
            hi_out <= div_rem;
            lo_out <= div_quo;
         end
      end
   end

   hilo_multdiv_div_iter #(
      .ITERS(DIV_ITERS)
   ) u_div_iter (
      .clk       (clk),
      .reset     (reset),
      .start     (accept && is_div_op),
      .abort     (flush),
      .dividend  (src_a),
      .divisor   (src_b),
      .is_signed (op_signed),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

endmodule

// File: tb/tb_hilo_multdiv.sv
// Scoreboard bench for hilo_multdiv: expected HI/LO pairs are queued at issue
// and popped by a monitor on every hilo_we; latency and hold behaviour checked inline.
module tb_hilo_multdiv;
   import hilo_multdiv_pkg::*;

   localparam int MUL_CYCLES = 1;
   localparam int DIV_ITERS  = 32;

   logic  clk = 1'b0;
   logic  reset = 1'b1;
   mult_t op = CLR;
   word_t src_a = '0;
   word_t src_b = '0;
   logic  flush = 1'b0;
   logic  ex_advance = 1'b0;
   logic  busy, hilo_we;
   word_t hi_out, lo_out;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_result = '0;

   always #5 clk = ~clk;

   hilo_multdiv #(
      .DIV_ITERS (DIV_ITERS),
      .MUL_CYCLES(MUL_CYCLES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush     (flush),
      .ex_advance(ex_advance),
      .busy      (busy),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .hilo_we   (hilo_we)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
   endtask

   // Architectural HI/LO result from plain integer arithmetic.
   function automatic logic [63:0] model(input mult_t o, input word_t a, input word_t b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = '0;
      case (o)
         MULT:  res = 64'(sa * sb);
         MULTU: res = {32'b0, a} * {32'b0, b};
         DIV: begin
            if (b == 0) res = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         DIVU: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, count busy cycles, then hold DONE for 'hold' cycles before advancing.
   task automatic run_op(input mult_t o, input word_t a, input word_t b, input int hold);
      int          cnt, exp_busy;
      logic [63:0] r;
      r = model(o, a, b);
      exp_q.push_back(r);
      last_result = r;
      exp_busy = (o == DIV || o == DIVU) ? DIV_ITERS + 1 : MUL_CYCLES + 1;
      next_cycle();
      op = o; src_a = a; src_b = b; flush = 1'b0;
      ex_advance = (hold == 0);
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
         cnt++;
      end
      chk("busy_cycles", 64'(cnt), 64'(exp_busy));
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            if (i > 0) begin
               next_cycle();
               @(negedge clk);
            end
            chk("hold_busy_we", {62'b0, busy, hilo_we}, 64'd0);
            chk("hold_result", {hi_out, lo_out}, r);
         end
         next_cycle();
         ex_advance = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic idle_cycle();
      next_cycle();
      op = CLR; ex_advance = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("idle_busy_we", {62'b0, busy, hilo_we}, 64'd0);
   endtask

   always @(negedge clk) begin
      if (!reset && hilo_we) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got hi=0x%h lo=0x%h, expected no write", hi_out, lo_out);
         end else begin
            chk("hilo_result", {hi_out, lo_out}, exp_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] prev;
      mult_t       o;
      word_t       a, b;
      int          mode;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_busy_we", {62'b0, busy, hilo_we}, 64'd0);
      chk("reset_hilo", {hi_out, lo_out}, 64'd0);

      run_op(MULT, 32'hFFFF_FFFE, 32'd3, 0);
      run_op(MULTU, 32'hFFFF_FFFE, 32'd3, 1);
      run_op(DIV, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(DIVU, 32'd7, 32'd2, 0);
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(DIVU, 32'h0000_1234, 32'd0, 0);
      run_op(DIV, 32'hFFFF_FFFB, 32'd0, 0);
      run_op(MULT, 32'h8000_0000, 32'h8000_0000, 3);
      run_op(DIV, 32'd100, 32'hFFFF_FFF9, 3);
      idle_cycle();

      // Flush in cycle 10 of a divide: nothing written, HI/LO untouched.
      prev = last_result;
      next_cycle();
      op = DIV; src_a = 32'd1000; src_b = 32'd7; ex_advance = 1'b0;
      repeat (10) next_cycle();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0; op = CLR;
      @(negedge clk);
      chk("flush_busy_we", {62'b0, busy, hilo_we}, 64'd0);
      chk("flush_hilo_kept", {hi_out, lo_out}, prev);
      idle_cycle();
      idle_cycle();
      run_op(MULTU, 32'd2, 32'd3, 0);

      repeat (24) begin
         o    = mult_t'($urandom_range(1, 4));
         a    = $urandom;
         b    = $urandom;
         mode = $urandom_range(0, 7);
         if (mode == 0) b = '0;
         else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (mode == 2) begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
         else if (mode == 3) b = $urandom_range(1, 3) - 2;
         run_op(o, a, b, $urandom_range(0, 2));
      end
      idle_cycle();

      // Reset in the middle of a divide clears the result registers.
      next_cycle();
      op = DIVU; src_a = 32'hDEAD_BEEF; src_b = 32'd3; ex_advance = 1'b0;
      repeat (5) next_cycle();
      reset = 1'b1; op = CLR;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_hilo", {hi_out, lo_out}, 64'd0);
      chk("midreset_busy_we", {62'b0, busy, hilo_we}, 64'd0);
      idle_cycle();

      run_op(DIVU, 32'd7, 32'd2, 0);
      idle_cycle();
      idle_cycle();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
